// File: rtl/control_seq.sv
// control_seq: tinyrv multicycle control FSM with a per-access memory watchdog, bounded retries and encoded trap causes.
// Strobes decode the registered state; the WFI sleep state exists only when CONTROL_SEQ_WFI_EN is defined.
module control_seq #(
  parameter int MEM_TIMEOUT = 64,
  parameter int RETRIES     = 1,
  parameter int CAUSE_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        iword,
  input  logic               mem_busy,
  input  logic               mem_valid,
  input  logic               interrupt_pending,
  input  logic [2:0]         exceptions,
  output logic [5:0]         control_flags,
  output logic               wbflag,
  output logic               memflag,
  output logic               pcflag,
  output logic               fetchflag,
  output logic               mem_ce,
  output logic               jump_to_isr,
  output logic               mret,
  output logic               csr_write,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               trap_is_irq
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] MRET_WORD = 32'h30200073;
`ifdef CONTROL_SEQ_WFI_EN
  localparam logic [31:0] WFI_WORD  = 32'h10500073;
`endif

  localparam logic [CAUSE_W-1:0] C_PC_MISALIGN = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] C_FETCH_FLT   = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] C_ILLEGAL     = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] C_LOAD_FLT    = CAUSE_W'(5);
  localparam logic [CAUSE_W-1:0] C_STORE_FLT   = CAUSE_W'(7);
  localparam logic [CAUSE_W-1:0] C_IRQ         = CAUSE_W'(11);
  localparam logic [2:0]         RETRY_MAX     = 3'(RETRIES);

  typedef enum logic [3:0] {
    RST, FETCH_AWAIT, FETCH, DECODE, EXECUTE, MEM_AWAIT, MEM, WRITEBACK, RETRY, TRAP
`ifdef CONTROL_SEQ_WFI_EN
    , WFI
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2:0]         retry_q, retry_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               irq_q, irq_d;
  logic               origin_mem_q, origin_mem_d;
  logic               cnt_hit, expire, expire_mem;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_mret, is_csrw;
  logic       f_jump, f_imm_as_b, f_auipc, f_reg_write, f_mem_write, f_mem_phase;

  assign opcode  = iword[6:0];
  assign funct3  = iword[14:12];
  assign is_mret = (iword == MRET_WORD);
  assign is_csrw = (opcode == OP_SYSTEM) && (funct3 == 3'b001);

  assign f_mem_phase = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign f_mem_write = (opcode == OP_STORE);
  assign f_reg_write = !((opcode == OP_BRANCH) || (opcode == OP_STORE) || is_csrw || is_mret);
  assign f_auipc     = (opcode == OP_AUIPC);
  assign f_imm_as_b  = (opcode == OP_OPIMM) || (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                       (opcode == OP_LOAD) || (opcode == OP_STORE) || (opcode == OP_JAL) ||
                       (opcode == OP_JALR);
  assign f_jump      = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  assign control_flags = {f_jump, f_imm_as_b, f_auipc, f_reg_write, f_mem_write, f_mem_phase};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    retry_d      = retry_q;
    cause_d      = cause_q;
    irq_d        = irq_q;
    origin_mem_d = origin_mem_q;
    expire       = 1'b0;
    expire_mem   = 1'b0;
    cnt_hit      = (count_q == CNT_W'(MEM_TIMEOUT - 1));

    // Exceptions are checked before progress, progress before the watchdog.
    case (state_q)
      RST:         state_d = FETCH_AWAIT;
      FETCH_AWAIT: begin
        if (exceptions[0]) begin
          state_d = TRAP; cause_d = C_PC_MISALIGN; irq_d = 1'b0;
        end else if (exceptions[2]) begin
          state_d = TRAP; cause_d = C_FETCH_FLT; irq_d = 1'b0;
        end else if (mem_busy) state_d = FETCH;
        else if (cnt_hit) expire = 1'b1;
      end
      FETCH: begin
        if (!mem_busy) state_d = DECODE;
        else if (cnt_hit) expire = 1'b1;
      end
      DECODE:      state_d = EXECUTE;
      EXECUTE: begin
        if (exceptions[1]) begin
          state_d = TRAP; cause_d = C_ILLEGAL; irq_d = 1'b0;
        end else if (f_mem_phase) state_d = MEM_AWAIT;
        else state_d = WRITEBACK;
      end
      MEM_AWAIT: begin
        if (exceptions[2]) begin
          state_d = TRAP; cause_d = f_mem_write ? C_STORE_FLT : C_LOAD_FLT; irq_d = 1'b0;
        end else if (mem_busy) state_d = MEM;
        else if (cnt_hit) begin
          expire = 1'b1; expire_mem = 1'b1;
        end
      end
      MEM: begin
        if (!mem_busy) state_d = WRITEBACK;
        else if (cnt_hit) begin
          expire = 1'b1; expire_mem = 1'b1;
        end
      end
      WRITEBACK: begin
        if (interrupt_pending) begin
          state_d = TRAP; cause_d = C_IRQ; irq_d = 1'b1;
`ifdef CONTROL_SEQ_WFI_EN
        end else if (iword == WFI_WORD) begin
          state_d = WFI;
`endif
        end else state_d = FETCH_AWAIT;
      end
      RETRY:       state_d = origin_mem_q ? MEM_AWAIT : FETCH_AWAIT;
      TRAP:        state_d = FETCH_AWAIT;
`ifdef CONTROL_SEQ_WFI_EN
      WFI: begin
        if (interrupt_pending) begin
          state_d = TRAP; cause_d = C_IRQ; irq_d = 1'b1;
        end
      end
`endif
      default:     state_d = RST;
    endcase

    if (expire) begin
      if (retry_q < RETRY_MAX) begin
        state_d      = RETRY;
        retry_d      = retry_q + 3'd1;
        origin_mem_d = expire_mem;
      end else begin
        state_d = TRAP;
        irq_d   = 1'b0;
        cause_d = !expire_mem ? C_FETCH_FLT : (f_mem_write ? C_STORE_FLT : C_LOAD_FLT);
      end
    end

    if ((state_d == FETCH_AWAIT && state_q != FETCH_AWAIT) ||
        (state_d == MEM_AWAIT && state_q != MEM_AWAIT))
      count_d = '0;
    else if (state_q == FETCH_AWAIT || state_q == FETCH || state_q == MEM_AWAIT || state_q == MEM)
      count_d = count_q + CNT_W'(1);

    if (state_d != state_q && (state_d == DECODE || state_d == WRITEBACK || state_d == TRAP))
      retry_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= RST;
      count_q      <= '0;
      retry_q      <= '0;
      cause_q      <= '0;
      irq_q        <= 1'b0;
      origin_mem_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      retry_q      <= retry_d;
      cause_q      <= cause_d;
      irq_q        <= irq_d;
      origin_mem_q <= origin_mem_d;
    end
  end

  assign fetchflag   = (state_q == FETCH) && mem_valid;
  assign memflag     = (state_q == MEM_AWAIT) || (state_q == MEM);
  assign mem_ce      = !((state_q == FETCH_AWAIT) || (state_q == FETCH) ||
                         (state_q == MEM_AWAIT) || (state_q == MEM));
  assign pcflag      = (state_q == WRITEBACK);
  assign wbflag      = (state_q == WRITEBACK) && f_reg_write;
  assign mret        = (state_q == WRITEBACK) && is_mret;
  assign csr_write   = (state_q == WRITEBACK) && is_csrw;
  assign jump_to_isr = (state_q == TRAP);
  assign trap_cause  = (state_q == TRAP) ? cause_q : '0;
  assign trap_is_irq = (state_q == TRAP) && irq_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq with a short watchdog (MEM_TIMEOUT=8, RETRIES=1).
module tb_control_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] iword;
  logic        mem_busy, mem_valid, interrupt_pending;
  logic [2:0]  exceptions;
  logic [5:0]  control_flags;
  logic        wbflag, memflag, pcflag, fetchflag, mem_ce, jump_to_isr, mret, csr_write;
  logic [3:0]  trap_cause;
  logic        trap_is_irq;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000a103;
  localparam logic [31:0] SW   = 32'h0020a023;
  localparam logic [31:0] NOP  = 32'h00000013;

  control_seq #(.MEM_TIMEOUT(8), .RETRIES(1), .CAUSE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .iword(iword), .mem_busy(mem_busy), .mem_valid(mem_valid),
    .interrupt_pending(interrupt_pending), .exceptions(exceptions), .control_flags(control_flags),
    .wbflag(wbflag), .memflag(memflag), .pcflag(pcflag), .fetchflag(fetchflag), .mem_ce(mem_ce),
    .jump_to_isr(jump_to_isr), .mret(mret), .csr_write(csr_write), .trap_cause(trap_cause),
    .trap_is_irq(trap_is_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH_AWAIT, memory busy for 2 cycles, ends in DECODE.
  task automatic do_fetch(input logic [31:0] iw);
    iword = iw;
    tick();
    mem_busy = 1'b1; tick(); tick();
    mem_busy = 1'b0; mem_valid = 1'b1; tick();
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(); tick();
    checks++; if (mem_ce !== 1'b1) begin fails++; $display("FAIL reset_mem_ce: got %b want 1", mem_ce); end
    checks++; if ({wbflag, memflag, pcflag, fetchflag, mret, csr_write} !== 6'b0) begin
      fails++; $display("FAIL reset_strobes: got %b want 000000", {wbflag, memflag, pcflag, fetchflag, mret, csr_write}); end
    checks++; if ({jump_to_isr, trap_is_irq, trap_cause} !== 6'b0) begin
      fails++; $display("FAIL reset_trap: got %b want 000000", {jump_to_isr, trap_is_irq, trap_cause}); end
    reset_n = 1'b1; tick();
    checks++; if (mem_ce !== 1'b0) begin fails++; $display("FAIL reset_to_fetch: mem_ce got %b want 0", mem_ce); end
  endtask

  task automatic test_addi();
    int start;
    start = cyc;
    iword = ADDI;
    tick();
    mem_busy = 1'b1; tick();
    checks++; if (fetchflag !== 1'b0) begin fails++; $display("FAIL addi_fetch_early: got %b want 0", fetchflag); end
    tick();
    mem_busy = 1'b0; mem_valid = 1'b1; #1;
    checks++; if (fetchflag !== 1'b1) begin fails++; $display("FAIL addi_fetchflag: got %b want 1", fetchflag); end
    tick(); mem_valid = 1'b0; #1;
    checks++; if ({fetchflag, mem_ce} !== 2'b01) begin fails++; $display("FAIL addi_decode: got %b want 01", {fetchflag, mem_ce}); end
    tick();
    checks++; if (control_flags !== 6'b010100) begin fails++; $display("FAIL addi_flags: got %b want 010100", control_flags); end
    tick();
    checks++; if ({wbflag, pcflag} !== 2'b11) begin fails++; $display("FAIL addi_wb: got %b want 11", {wbflag, pcflag}); end
    tick();
    checks++; if ({mem_ce, pcflag} !== 2'b00) begin fails++; $display("FAIL addi_refetch: got %b want 00", {mem_ce, pcflag}); end
    checks++; if (cyc - start !== 7) begin fails++; $display("FAIL addi_cycles: got %0d want 7", cyc - start); end
  endtask

  task automatic test_load_store();
    do_fetch(LW); tick();
    checks++; if (control_flags !== 6'b010101) begin fails++; $display("FAIL lw_flags: got %b want 010101", control_flags); end
    tick();
    checks++; if ({memflag, mem_ce} !== 2'b10) begin fails++; $display("FAIL lw_await: got %b want 10", {memflag, mem_ce}); end
    tick();
    mem_busy = 1'b1; tick(); tick(); tick();
    checks++; if ({memflag, mem_ce} !== 2'b10) begin fails++; $display("FAIL lw_mem: got %b want 10", {memflag, mem_ce}); end
    mem_busy = 1'b0; tick();
    checks++; if ({wbflag, memflag, mem_ce} !== 3'b101) begin fails++; $display("FAIL lw_wb: got %b want 101", {wbflag, memflag, mem_ce}); end
    tick();
    do_fetch(SW); tick();
    checks++; if (control_flags !== 6'b010011) begin fails++; $display("FAIL sw_flags: got %b want 010011", control_flags); end
    tick(); mem_busy = 1'b1; tick(); mem_busy = 1'b0; tick();
    checks++; if ({wbflag, pcflag} !== 2'b01) begin fails++; $display("FAIL sw_wb: got %b want 01", {wbflag, pcflag}); end
    tick();
  endtask

  task automatic test_timeout();
    iword = NOP;
    repeat (7) tick();
    checks++; if (mem_ce !== 1'b0) begin fails++; $display("FAIL to_before_retry: mem_ce got %b want 0", mem_ce); end
    tick();
    checks++; if ({mem_ce, jump_to_isr} !== 2'b10) begin fails++; $display("FAIL to_retry: got %b want 10", {mem_ce, jump_to_isr}); end
    tick();
    checks++; if (mem_ce !== 1'b0) begin fails++; $display("FAIL to_reissue: mem_ce got %b want 0", mem_ce); end
    repeat (7) tick();
    checks++; if ({mem_ce, jump_to_isr} !== 2'b00) begin fails++; $display("FAIL to_before_trap: got %b want 00", {mem_ce, jump_to_isr}); end
    tick();
    checks++; if ({jump_to_isr, trap_is_irq, trap_cause} !== 6'b1_0_0001) begin
      fails++; $display("FAIL to_trap: got %b want 100001", {jump_to_isr, trap_is_irq, trap_cause}); end
    tick();
    checks++; if ({jump_to_isr, mem_ce} !== 2'b00) begin fails++; $display("FAIL to_after_trap: got %b want 00", {jump_to_isr, mem_ce}); end
  endtask

  task automatic test_completion_wins();
    iword = ADDI;
    tick();
    mem_busy = 1'b1; repeat (6) tick();
    mem_busy = 1'b0; mem_valid = 1'b1; tick();
    mem_valid = 1'b0;
    tick();
    checks++; if (mem_ce !== 1'b1) begin fails++; $display("FAIL edge_complete: mem_ce got %b want 1", mem_ce); end
    tick();
    checks++; if (pcflag !== 1'b1) begin fails++; $display("FAIL edge_wb: pcflag got %b want 1", pcflag); end
    tick();
  endtask

  task automatic test_exceptions();
    exceptions = 3'b101; tick(); exceptions = 3'b000;
    checks++; if ({jump_to_isr, trap_cause} !== 5'b1_0000) begin fails++; $display("FAIL exc_misalign: got %b want 10000", {jump_to_isr, trap_cause}); end
    tick();
    exceptions = 3'b100; tick(); exceptions = 3'b000;
    checks++; if ({jump_to_isr, trap_cause} !== 5'b1_0001) begin fails++; $display("FAIL exc_fetch_fault: got %b want 10001", {jump_to_isr, trap_cause}); end
    tick();
    do_fetch(ADDI); tick();
    exceptions = 3'b010; tick(); exceptions = 3'b000;
    checks++; if ({jump_to_isr, pcflag, trap_is_irq, trap_cause} !== 7'b1_0_0_0010) begin
      fails++; $display("FAIL exc_illegal: got %b want 1000010", {jump_to_isr, pcflag, trap_is_irq, trap_cause}); end
    tick();
    do_fetch(SW); tick(); tick();
    exceptions = 3'b100; tick(); exceptions = 3'b000;
    checks++; if ({jump_to_isr, trap_cause} !== 5'b1_0111) begin fails++; $display("FAIL exc_store_fault: got %b want 10111", {jump_to_isr, trap_cause}); end
    tick();
  endtask

  task automatic test_interrupt();
    do_fetch(ADDI); tick();
    interrupt_pending = 1'b1; tick();
    checks++; if (pcflag !== 1'b1) begin fails++; $display("FAIL irq_wb: pcflag got %b want 1", pcflag); end
    tick();
    checks++; if ({jump_to_isr, trap_is_irq, trap_cause} !== 6'b1_1_1011) begin
      fails++; $display("FAIL irq_trap: got %b want 111011", {jump_to_isr, trap_is_irq, trap_cause}); end
    interrupt_pending = 1'b0; tick();
    checks++; if ({jump_to_isr, trap_is_irq} !== 2'b00) begin fails++; $display("FAIL irq_after: got %b want 00", {jump_to_isr, trap_is_irq}); end
  endtask

  task automatic test_system();
    do_fetch(32'h30200073); tick(); tick();
    checks++; if ({mret, wbflag, csr_write} !== 3'b100) begin fails++; $display("FAIL mret_wb: got %b want 100", {mret, wbflag, csr_write}); end
    tick();
    do_fetch(32'h30001073); tick(); tick();
    checks++; if ({csr_write, wbflag, mret} !== 3'b100) begin fails++; $display("FAIL csrw_wb: got %b want 100", {csr_write, wbflag, mret}); end
    tick();
  endtask

  task automatic test_wfi();
    do_fetch(32'h10500073); tick(); tick();
    checks++; if (pcflag !== 1'b1) begin fails++; $display("FAIL wfi_wb: pcflag got %b want 1", pcflag); end
`ifdef CONTROL_SEQ_WFI_EN
    tick(); repeat (3) tick();
    checks++; if ({mem_ce, pcflag, wbflag, jump_to_isr} !== 4'b1000) begin
      fails++; $display("FAIL wfi_hold: got %b want 1000", {mem_ce, pcflag, wbflag, jump_to_isr}); end
    interrupt_pending = 1'b1; tick(); interrupt_pending = 1'b0;
    checks++; if ({jump_to_isr, trap_is_irq, trap_cause} !== 6'b1_1_1011) begin
      fails++; $display("FAIL wfi_wake: got %b want 111011", {jump_to_isr, trap_is_irq, trap_cause}); end
    tick();
`else
    checks++; if (wbflag !== 1'b1) begin fails++; $display("FAIL wfi_nop_wb: wbflag got %b want 1", wbflag); end
    tick();
    checks++; if (mem_ce !== 1'b0) begin fails++; $display("FAIL wfi_nop_next: mem_ce got %b want 0", mem_ce); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    do_fetch(LW); tick(); tick();
    mem_busy = 1'b1; tick();
    checks++; if ({memflag, mem_ce} !== 2'b10) begin fails++; $display("FAIL rst_in_mem: got %b want 10", {memflag, mem_ce}); end
    reset_n = 1'b0; tick();
    checks++; if ({mem_ce, memflag, wbflag, pcflag, jump_to_isr} !== 5'b10000) begin
      fails++; $display("FAIL rst_mid_mem: got %b want 10000", {mem_ce, memflag, wbflag, pcflag, jump_to_isr}); end
    mem_busy = 1'b0; reset_n = 1'b1; tick();
    checks++; if (mem_ce !== 1'b0) begin fails++; $display("FAIL rst_recover: mem_ce got %b want 0", mem_ce); end
  endtask

  initial begin
    reset_n = 1'b0; iword = NOP; mem_busy = 1'b0; mem_valid = 1'b0;
    interrupt_pending = 1'b0; exceptions = 3'b000;
    test_reset();
    test_addi();
    test_load_store();
    test_timeout();
    test_completion_wins();
    test_exceptions();
    test_interrupt();
    test_system();
    test_wfi();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
